// File: rtl/nibble_serial_add_ctrl.sv
// 16-bit add/subtract built from one 4-bit adder slice, LSB nibble first.
// IDLE -> RUN (4 nibbles) -> DONE, with back-to-back accept from DONE.
module nibble_serial_add_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sub,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] sum,
    output logic        cout,
    output logic        ovfl,
    output logic        zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    logic [15:0] acc_q, acc_d;
    logic        carry_q, carry_d;
    logic [15:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic        ovfl_q, ovfl_d;
    logic        zero_q, zero_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [4:0]  nib_s;
    logic [15:0] res;

    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        unique case (cnt_q)
            2'd0: begin
                nib_a = opa_q[3:0];
                nib_b = opb_q[3:0];
            end
            2'd1: begin
                nib_a = opa_q[7:4];
                nib_b = opb_q[7:4];
            end
            2'd2: begin
                nib_a = opa_q[11:8];
                nib_b = opb_q[11:8];
            end
            default: begin
                nib_a = opa_q[15:12];
                nib_b = opb_q[15:12];
            end
        endcase
    end

    assign nib_s = {1'b0, nib_a} + {1'b0, nib_b} + {4'h0, carry_q};
    assign res   = {nib_s[3:0], acc_q[11:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovfl_d  = ovfl_q;
        zero_d  = zero_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // B is pre-inverted so subtraction reuses the same slice
                    opa_d   = a;
                    opb_d   = b ^ {16{sub}};
                    carry_d = sub;
                    cnt_d   = 2'd0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                unique case (cnt_q)
                    2'd0:    acc_d[3:0]   = nib_s[3:0];
                    2'd1:    acc_d[7:4]   = nib_s[3:0];
                    2'd2:    acc_d[11:8]  = nib_s[3:0];
                    default: acc_d[15:12] = nib_s[3:0];
                endcase
                carry_d = nib_s[4];
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    sum_d   = res;
                    cout_d  = nib_s[4];
                    ovfl_d  = (opa_q[15] & opb_q[15] & ~res[15])
                            | (~opa_q[15] & ~opb_q[15] & res[15]);
                    zero_d  = (res == 16'h0000);
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            opa_q   <= 16'h0000;
            opb_q   <= 16'h0000;
            acc_q   <= 16'h0000;
            carry_q <= 1'b0;
            sum_q   <= 16'h0000;
            cout_q  <= 1'b0;
            ovfl_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovfl_q  <= ovfl_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovfl = ovfl_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench: driver pushes expected results with their due edge,
// monitor checks done/busy/outputs after every rising edge.
module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovfl;
    logic        zero;

    nibble_serial_add_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sub  (sub),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .ovfl (ovfl),
        .zero (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          done_edge;
        logic [15:0] s;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    exp_t        sb_q[$];
    int          edge_n    = 0;
    int          next_free = 0;
    int          checks    = 0;
    int          errors    = 0;
    logic [15:0] last_s    = 16'h0;
    logic        last_c    = 1'b0;
    logic        last_v    = 1'b0;
    logic        last_z    = 1'b0;

    function automatic exp_t ref_op(logic sb, logic [15:0] av,
                                    logic [15:0] bv, int de);
        exp_t e;
        int sa, sbv, ua, ub, r;
        sa  = $signed(av);
        sbv = $signed(bv);
        ua  = int'(av);
        ub  = int'(bv);
        if (sb) begin
            r   = sa - sbv;
            e.s = 16'(ua - ub);
            e.c = (ua >= ub);
        end else begin
            r   = sa + sbv;
            e.s = 16'(ua + ub);
            e.c = ((ua + ub) > 65535);
        end
        e.v = (r > 32767) || (r < -32768);
        e.z = (e.s == 16'h0000);
        e.done_edge = de;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h",
                     name, edge_n, act, exp);
        end
    endtask

    // Drive inputs for the coming edge and update the reference model.
    task automatic step(logic r, logic s, logic sb,
                        logic [15:0] av, logic [15:0] bv);
        int e;
        rst   = r;
        start = s;
        sub   = sb;
        a     = av;
        b     = bv;
        e     = edge_n + 1;
        if (r) begin
            sb_q.delete();
            next_free = e + 1;
            last_s = 16'h0;
            last_c = 1'b0;
            last_v = 1'b0;
            last_z = 1'b0;
        end else if (s && e >= next_free) begin
            sb_q.push_back(ref_op(sb, av, bv, e + 4));
            next_free = e + 5;
        end
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // Monitor
    initial begin
        logic exp_done, exp_busy;
        exp_t e;
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            exp_done = (sb_q.size() > 0) && (sb_q[0].done_edge == edge_n);
            exp_busy = (sb_q.size() > 0) && (edge_n >= sb_q[0].done_edge - 4)
                       && (edge_n < sb_q[0].done_edge);
            chk("done", 32'(done), 32'(exp_done));
            chk("busy", 32'(busy), 32'(exp_busy));
            if (exp_done) begin
                e = sb_q.pop_front();
                last_s = e.s;
                last_c = e.c;
                last_v = e.v;
                last_z = e.z;
            end
            chk("sum", 32'(sum), 32'(last_s));
            chk("flags", {29'h0, cout, ovfl, zero},
                {29'h0, last_c, last_v, last_z});
        end
    end

    logic [15:0] corners [8] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000,
                                 16'hFFFF, 16'h8001, 16'h00FF, 16'h0F0F};

    function automatic logic [15:0] rnd_op();
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 7)];
        return 16'($urandom);
    endfunction

    initial begin
        step(1'b1, 1'b1, 1'b0, 16'h1234, 16'h1111);
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(2);

        step(1'b0, 1'b1, 1'b0, 16'h7FFF, 16'h0001);
        idle(6);
        step(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0001);
        idle(6);
        step(1'b0, 1'b1, 1'b1, 16'h0005, 16'h0007);
        idle(6);
        step(1'b0, 1'b1, 1'b1, 16'h8000, 16'h0001);
        idle(6);

        // start during RUN is ignored
        step(1'b0, 1'b1, 1'b0, 16'h1111, 16'h2222);
        idle(1);
        step(1'b0, 1'b1, 1'b1, 16'hAAAA, 16'h5555);
        idle(6);

        // start held through DONE gives back-to-back operations
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, i[0], 16'h4000 + 16'(i), 16'h3000 - 16'(i));
        idle(6);

        // reset in the second RUN cycle aborts
        step(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(6);

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 39) == 0, 1'($urandom),
                 1'($urandom), rnd_op(), rnd_op());
        idle(8);

        chk("drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
